// File: rtl/serial_tx_pkg.sv
// Shared types and line levels for the serial transmit framer.
package serial_tx_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;
endpackage

// File: rtl/serial_tx_framer_if.sv
// Word handshake plus serial line/status bundle for serial_tx_framer.
interface serial_tx_framer_if #(
  parameter int NUM_BITS = 8
);
  logic [NUM_BITS-1:0] tx_data;
  logic                tx_valid;
  logic                tx_ready;
  logic                serial_out;
  logic                tx_busy;
  logic                tx_done;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, serial_out, tx_busy, tx_done
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, serial_out, tx_busy, tx_done
  );
endinterface

// File: rtl/flex_pts_sr.sv
// Parallel-to-serial shift register; idles at all ones so an unloaded shift reads as line-idle.
module flex_pts_sr #(
  parameter int NUM_BITS  = 8,
  parameter int SHIFT_MSB = 1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                load_enable,
  input  logic                shift_enable,
  input  logic [NUM_BITS-1:0] parallel_in,
  output logic                serial_out
);
  logic [NUM_BITS-1:0] sr;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      sr <= '1;
    else if (load_enable)
      sr <= parallel_in;
    else if (shift_enable) begin
      if (SHIFT_MSB != 0)
        sr <= {sr[NUM_BITS-2:0], 1'b1};
      else
        sr <= {1'b1, sr[NUM_BITS-1:1]};
    end
  end

  assign serial_out = (SHIFT_MSB != 0) ? sr[NUM_BITS-1] : sr[0];
endmodule

// File: rtl/serial_tx_framer.sv
// Framed serial transmitter: start, NUM_BITS data, optional parity, stop bit(s), each CLKS_PER_BIT clocks.
module serial_tx_framer
  import serial_tx_pkg::*;
#(
  parameter int NUM_BITS     = 8,
  parameter int SHIFT_MSB    = 1,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic               clk,
  input  logic               n_rst,
  serial_tx_framer_if.slave  bus
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int IW = $clog2(NUM_BITS + 2);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(NUM_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
  localparam logic          PAR_INIT  = (PARITY_ODD != 0);

  tx_state_t     state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          par_q;
  logic          sr_out;
  logic          accept;
  logic          bit_end;
  logic          shift_en;
  logic          line;

  assign accept   = (state == IDLE) && bus.tx_valid;
  assign bit_end  = (cnt == CNT_LAST);
  assign shift_en = (state == DATA) && bit_end;

  flex_pts_sr #(
    .NUM_BITS  (NUM_BITS),
    .SHIFT_MSB (SHIFT_MSB)
  ) u_sr (
    .clk          (clk),
    .n_rst        (n_rst),
    .load_enable  (accept),
    .shift_enable (shift_en),
    .parallel_in  (bus.tx_data),
    .serial_out   (sr_out)
  );

  // cnt times the current bit; idx counts data bits, then stop bits.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      par_q <= 1'b0;
    end else if (state == IDLE) begin
      if (bus.tx_valid) begin
        state <= START;
        cnt   <= '0;
        idx   <= '0;
        par_q <= (^bus.tx_data) ^ PAR_INIT;
      end
    end else if (!bit_end) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
      case (state)
        START: state <= DATA;
        DATA: begin
          if (idx == DATA_LAST) begin
            idx   <= '0;
            state <= (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        PARITY: state <= STOP;
        STOP: begin
          if (idx == STOP_LAST) begin
            idx   <= '0;
            state <= IDLE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line is a pure decode of flops, so reset drives it high without waiting for a clock.
  always_comb begin
    line = LINE_IDLE;
    case (state)
      START:   line = START_LVL;
      DATA:    line = sr_out;
      PARITY:  line = par_q;
      default: line = LINE_IDLE;
    endcase
  end

  assign bus.serial_out = line;
  assign bus.tx_ready   = (state == IDLE);
  assign bus.tx_busy    = (state != IDLE);
  assign bus.tx_done    = (state == STOP) && bit_end && (idx == STOP_LAST);
endmodule

// File: tb/tb_serial_tx_framer.sv
// Directed bench for serial_tx_framer across four parameter sets, checked cycle by cycle.
module tb_serial_tx_framer;
  logic clk;
  logic n_rst;
  logic       tv [4];
  logic [7:0] td [4];
  logic ln [4];
  logic rd [4];
  logic bz [4];
  logic dn [4];
  int chk_cnt  = 0;
  int pass_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // a: MSB, 4 clk/bit, no parity, 1 stop   b: LSB, even parity, 2 stop
  // c: MSB, odd parity, 1 stop             d: 2 bits, 1 clk/bit
  serial_tx_framer_if #(.NUM_BITS(8)) if_a ();
  serial_tx_framer_if #(.NUM_BITS(8)) if_b ();
  serial_tx_framer_if #(.NUM_BITS(8)) if_c ();
  serial_tx_framer_if #(.NUM_BITS(2)) if_d ();

  serial_tx_framer #(.NUM_BITS(8), .SHIFT_MSB(1), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    u_a (.clk(clk), .n_rst(n_rst), .bus(if_a));
  serial_tx_framer #(.NUM_BITS(8), .SHIFT_MSB(0), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2))
    u_b (.clk(clk), .n_rst(n_rst), .bus(if_b));
  serial_tx_framer #(.NUM_BITS(8), .SHIFT_MSB(1), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
    u_c (.clk(clk), .n_rst(n_rst), .bus(if_c));
  serial_tx_framer #(.NUM_BITS(2), .SHIFT_MSB(1), .CLKS_PER_BIT(1), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    u_d (.clk(clk), .n_rst(n_rst), .bus(if_d));

  assign if_a.tx_data = td[0];      assign if_a.tx_valid = tv[0];
  assign if_b.tx_data = td[1];      assign if_b.tx_valid = tv[1];
  assign if_c.tx_data = td[2];      assign if_c.tx_valid = tv[2];
  assign if_d.tx_data = td[3][1:0]; assign if_d.tx_valid = tv[3];

  assign ln[0] = if_a.serial_out; assign rd[0] = if_a.tx_ready; assign bz[0] = if_a.tx_busy; assign dn[0] = if_a.tx_done;
  assign ln[1] = if_b.serial_out; assign rd[1] = if_b.tx_ready; assign bz[1] = if_b.tx_busy; assign dn[1] = if_b.tx_done;
  assign ln[2] = if_c.serial_out; assign rd[2] = if_c.tx_ready; assign bz[2] = if_c.tx_busy; assign dn[2] = if_c.tx_done;
  assign ln[3] = if_d.serial_out; assign rd[3] = if_d.tx_ready; assign bz[3] = if_d.tx_busy; assign dn[3] = if_d.tx_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Caller has set valid/data just after a posedge; the next edge accepts.
  // exp holds the frame bits first-on-the-line in bit nb-1.
  task automatic run_frame(input int sel, input logic [15:0] exp, input int nb, input int cpb,
                           input bit drop, output logic [15:0] cap);
    int total;
    int b;
    total = nb * cpb;
    cap = '0;
    @(posedge clk); #1;
    for (int c = 1; c <= total; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (c == 1 && drop) tv[sel] = 1'b0;
      b = nb - 1 - (c - 1) / cpb;
      chk($sformatf("u%0d line c%0d", sel, c), ln[sel], exp[b]);
      chk($sformatf("u%0d ready c%0d", sel, c), rd[sel], 0);
      chk($sformatf("u%0d busy c%0d", sel, c), bz[sel], 1);
      chk($sformatf("u%0d done c%0d", sel, c), dn[sel], (c == total) ? 1 : 0);
      if ((c - 1) % cpb == cpb / 2) cap[b] = ln[sel];
    end
  endtask

  task automatic idle_chk(input int sel, input string tag);
    chk($sformatf("%s line", tag), ln[sel], 1);
    chk($sformatf("%s ready", tag), rd[sel], 1);
    chk($sformatf("%s done", tag), dn[sel], 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] cap;
    logic [7:0]  rec;
    n_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin tv[i] = 1'b0; td[i] = 8'h00; end
    #12;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst u%0d line", i), ln[i], 1);
      chk($sformatf("rst u%0d ready", i), rd[i], 1);
      chk($sformatf("rst u%0d busy", i), bz[i], 0);
      chk($sformatf("rst u%0d done", i), dn[i], 0);
    end
    #10 n_rst = 1'b1;

    // valid low: stays idle
    repeat (3) begin @(posedge clk); #1; idle_chk(0, "idle a"); end

    // a: 0xA5 MSB-first -> 0 10100101 1
    td[0] = 8'hA5; tv[0] = 1'b1;
    run_frame(0, 16'b0101001011, 10, 4, 1'b1, cap);
    @(posedge clk); #1; idle_chk(0, "post a");

    // c: 0xA5 odd parity -> parity bit 1
    td[2] = 8'hA5; tv[2] = 1'b1;
    run_frame(2, 16'b01010010111, 11, 4, 1'b1, cap);
    chk("c parity", cap[1], 1);
    @(posedge clk); #1; idle_chk(2, "post c");

    // b: 0xA5 LSB-first, even parity 0, two stops; mid-bit samples rebuild the word
    td[1] = 8'hA5; tv[1] = 1'b1;
    run_frame(1, 16'b010100101011, 12, 4, 1'b1, cap);
    for (int i = 0; i < 8; i++) rec[i] = cap[10 - i];
    chk("b loopback", rec, 8'hA5);
    chk("b parity a5", cap[2], 0);
    @(posedge clk); #1; idle_chk(1, "post b");

    // b: 0x01 even parity -> 1
    td[1] = 8'h01; tv[1] = 1'b1;
    run_frame(1, 16'b010000000111, 12, 4, 1'b1, cap);
    chk("b parity 01", cap[2], 1);
    @(posedge clk); #1; idle_chk(1, "post b01");

    // b back-to-back, valid held: 0x3C, data churns mid-frame, then 0xC3
    td[1] = 8'h3C; tv[1] = 1'b1;
    fork
      run_frame(1, 16'b000111100011, 12, 4, 1'b0, cap);
      begin
        repeat (5) @(posedge clk);
        #1 td[1] = 8'hFF;
        repeat (10) @(posedge clk);
        #1 td[1] = 8'hC3;
      end
    join
    @(posedge clk); #1; idle_chk(1, "gap b2b");
    run_frame(1, 16'b011000011011, 12, 4, 1'b1, cap);
    @(posedge clk); #1; idle_chk(1, "post b2b");

    // d: 2'b10 at 1 clk/bit -> 0,1,0,1
    td[3] = 8'h02; tv[3] = 1'b1;
    run_frame(3, 16'b0101, 4, 1, 1'b1, cap);
    @(posedge clk); #1; idle_chk(3, "post d");

    // reset mid-DATA of an 0xA5 frame on a
    td[0] = 8'hA5; tv[0] = 1'b1;
    @(posedge clk); #1; tv[0] = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    chk("pre-rst busy", bz[0], 1);
    n_rst = 1'b0;
    #1;
    chk("async rst line", ln[0], 1);
    chk("async rst ready", rd[0], 1);
    chk("async rst busy", bz[0], 0);
    #3 n_rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk($sformatf("after rst line %0d", i), ln[0], 1);
      chk($sformatf("after rst ready %0d", i), rd[0], 1);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/serial_tx_framer.md
Name: serial_tx_framer

Overview:
- Transmit-side counterpart to the team's serial-to-parallel receive path.
- Accepts a parallel word over a valid/ready handshake and drives a framed, idle-high serial line: start bit, NUM_BITS data bits, optional parity, then stop bit(s).
- Each bit is held for CLKS_PER_BIT clocks.
- Bit order is selectable so the stream reassembles correctly in a receiver of the same SHIFT_MSB setting.

Parameters:
- NUM_BITS, 8, data bits per frame (2..16).
- SHIFT_MSB, 1, 1 = MSB transmitted first, 0 = LSB first.
- CLKS_PER_BIT, 4, clocks per serial bit (>= 1).
- PARITY_EN, 0, 1 = insert one parity bit after the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity (used only when PARITY_EN = 1).
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  asynchronous active-low reset.
- tx_data  input  NUM_BITS  word to send; sampled only on handshake.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  framer can accept a word (high only in IDLE).
- serial_out  output  1  serial line; idle/stop = 1, start = 0.
- tx_busy  output  1  frame in progress (any state other than IDLE).
- tx_done  output  1  one-cycle pulse on the last clock of the final stop bit.

Behaviour:
- Clock and reset: one clock, clk. Reset n_rst is asynchronous and active-low.
- Reset values: state IDLE, serial_out = 1, tx_ready = 1, tx_busy = 0, tx_done = 0, shift register all ones, counters 0.
- Reset mid-frame: aborts immediately; the line returns high asynchronously and the partial frame is not resumed.
- Handshake: a word is accepted on a rising edge where tx_valid && tx_ready.
  - tx_data is latched into the shift register on that edge.
  - Later changes to tx_data or tx_valid have no effect on the frame in flight.
  - tx_valid low in IDLE: remain IDLE, line high.
- States (registered serial_out, one state per bit field):
  - IDLE: out = 1, tx_ready = 1. On handshake -> START.
  - START: out = 0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: out = current shift register bit (MSB if SHIFT_MSB, else LSB) for CLKS_PER_BIT cycles each. Shift once per bit period, filling with 1. After NUM_BITS bits -> PARITY if PARITY_EN, else STOP.
  - PARITY: out = XOR of the latched word, XOR PARITY_ODD, for CLKS_PER_BIT cycles -> STOP.
  - STOP: out = 1 for STOP_BITS*CLKS_PER_BIT cycles. tx_done is asserted on the last cycle -> IDLE.
- Latency:
  - First start-bit cycle appears on serial_out the cycle after the accepting edge.
  - Frame occupancy = (1 + NUM_BITS + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles, with the line exact to the cycle.
- Back-to-back: IDLE lasts at least one cycle between frames (tx_ready high there). With tx_valid held high, successive frames are separated by exactly one idle-high clock.
- Counters:
  - Bit-period counter width $clog2(CLKS_PER_BIT+1); reloads at each bit boundary.
  - Bit-index counter width $clog2(NUM_BITS+2).
  - Neither counter may wrap inside a field.
- CLKS_PER_BIT = 1: every field advances each cycle with no dead cycles.
- Parity is computed from the latched word at acceptance, not from the shifting register.

Decomposition:
- Package serial_tx_pkg holds:
  - typedef enum logic [2:0] tx_state_t {IDLE, START, DATA, PARITY, STOP};
  - constants LINE_IDLE = 1'b1 and START_LVL = 1'b0.
- Sub-module flex_pts_sr (parallel-to-serial shift register):
  - Parameters NUM_BITS, SHIFT_MSB.
  - Ports clk, n_rst, load_enable, shift_enable, parallel_in, serial_out.
  - Resets to all ones, fills with 1 on shift, load has priority over shift.
- The framer FSM instantiates one flex_pts_sr and owns both counters.

Test Plan:
- Reset: assert n_rst low mid-DATA of a 0xA5 frame -> serial_out = 1 and tx_ready = 1 within the same cycle; no further data bits.
- Basic MSB-first (NUM_BITS=8, CLKS_PER_BIT=4): send 0xA5 -> line 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles (40 cycles). tx_done pulses at cycle 40; tx_ready low cycles 1-40.
- LSB-first (SHIFT_MSB=0): send 0xA5 -> data bits 1,0,1,0,0,1,0,1. Loopback through flex_stp_sr with SHIFT_MSB=0 sampled mid-bit recovers 0xA5.
- Parity (PARITY_EN=1): 0xA5 with even parity -> parity bit 0; odd -> 1. 0x01 with even parity -> 1. Frame = 11 bits.
- Back-to-back with STOP_BITS=2: tx_valid held high with 0x3C then 0xC3 -> exactly one idle-high cycle between frames, 2 stop bits each. tx_data changed mid-frame is not transmitted until the next handshake.
- Corner (CLKS_PER_BIT=1, NUM_BITS=2): send 2'b10 -> line 0,1,0,1 on consecutive cycles; tx_done on cycle 4.
